dcache_sram_nway: RTL
=====================

DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 Parameters SHALL be: WAYS, default 2, associativity (legal 2, 4, 8).
REQ-002 Parameters SHALL be: SETS, default 16, number of sets (power of two); IDX_W = log2(SETS).
REQ-003 Parameters SHALL be: TAG_W, default 23, stored tag width.
REQ-004 Parameters SHALL be: LINE_W, default 256, line width in bits.
REQ-005 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n_i  in  1  synchronous, active-low reset.
REQ-007 req_i  in  1  lookup/write request; accepted only when busy_o=0.
REQ-008 write_i  in  1  1 = write/fill, 0 = read lookup.
REQ-009 index_i  in  IDX_W  set index.
REQ-010 tag_i  in  TAG_W  request tag.
REQ-011 data_i  in  LINE_W  write line.
REQ-012 dirty_i  in  1  mark written line dirty.
REQ-013 flush_i  in  1  start write-back-and-invalidate of whole cache.
REQ-014 wb_ready_i  in  1  downstream accepts write-back beat.
REQ-015 rsp_valid_o  out  1  one-cycle pulse: response fields valid.
REQ-016 hit_o, data_o, tag_o  out  1/LINE_W/TAG_W  hit flag, hit line, hit tag.
REQ-017 victim_valid_o, victim_tag_o, victim_data_o  out  1/TAG_W/LINE_W  dirty line evicted by a write miss.
REQ-018 wb_valid_o, wb_index_o, wb_tag_o, wb_data_o  out  1/IDX_W/TAG_W/LINE_W  flush write-back beat.
REQ-019 busy_o  out  1  registered; high while flush in progress.
REQ-020 flush_done_o  out  1  one-cycle pulse at flush completion.

Function
REQ-021 Per line SHALL hold valid, dirty, tag, data; per way per set an age counter of log2(WAYS) bits.
REQ-022 Accepted request SHALL produce rsp_valid_o exactly one cycle later; responses fully registered.
REQ-023 Hit = valid and tag match in any way; data_o/tag_o SHALL be zero on miss.
REQ-024 Read hit: return line, update LRU; read miss: no state change.
REQ-025 Write hit: overwrite data in matching way, dirty <= dirty | dirty_i, update LRU, hit_o=1.
REQ-026 Write miss: target = lowest-index invalid way, else way with age WAYS-1; write valid=1, dirty=dirty_i, tag, data; update LRU; hit_o=0.
REQ-027 If write-miss target was valid and dirty, victim_* SHALL carry its pre-write tag/data with victim_valid_o=1 in the response cycle; otherwise victim outputs zero.
REQ-028 LRU update on access to way w with age a: ways in set with age < a increment, way w age <= 0; ages remain a permutation of 0..WAYS-1.
REQ-029 FSM states: IDLE, SCAN, WB, DONE.
REQ-030 IDLE: flush_i=1 -> SCAN, cursor (set 0, way 0), busy_o=1 next cycle; flush_i has priority over req_i in same cycle (request dropped, no rsp).
REQ-031 SCAN: valid and dirty line at cursor -> WB; else invalidate it, advance cursor (way first, then set); after last line -> DONE.
REQ-032 WB: wb_valid_o=1 with stable line fields until wb_ready_i=1; on handshake invalidate line, clear dirty, advance cursor, return SCAN (or DONE after last).
REQ-033 DONE: flush_done_o=1 one cycle, ages reset to way index, -> IDLE, busy_o=0 next cycle.
REQ-034 req_i while busy_o=1 SHALL be ignored with no response.

Reset
REQ-035 rst_n_i=0 at a clock edge SHALL clear all valid/dirty bits, set age of way w to w, FSM to IDLE, all outputs to 0; data/tag arrays not cleared.
REQ-036 Reset during flush SHALL abort it; pending write-back dropped, no flush_done_o.

Verification
REQ-037 Reset, read idx 3 tag 0x5 -> next cycle rsp_valid_o=1, hit_o=0, data_o=0.
REQ-038 Write idx 3 tag 0x5 data 0xA5..A5, then read -> rsp one cycle after request, hit_o=1, data_o=0xA5..A5, tag_o=0x5.
REQ-039 WAYS=4: write tags 1,2,3,4 to set 0 (dirty_i=1), read tag 1, write tag 5 -> tag 2 evicted, victim_valid_o=1, victim_tag_o=2.
REQ-040 Two dirty lines (set 0 way 1, set 15 way 0), flush_i, wb_ready_i low 3 cycles -> wb_valid_o held with stable fields, two beats in cursor order, flush_done_o once, later reads miss.
REQ-041 flush_i and req_i same cycle -> no rsp_valid_o, busy_o=1 next cycle.
REQ-042 rst_n_i low during WB -> wb_valid_o=0 next cycle, busy_o=0, all lookups miss.

Source files
------------

// File: rtl/dcache_sram_nway.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sram_nway
// Description : N-way set-associative data-cache array with true-LRU age
//               counters. A lookup or write gets a registered response one
//               cycle after it is accepted. A flush walks every line,
//               streams dirty lines out as write-back beats, and invalidates
//               the whole cache.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    input  logic              flush_i,
    input  logic              wb_ready_i,
    output logic              rsp_valid_o,
    output logic              hit_o,
    output logic [LINE_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              victim_valid_o,
    output logic [TAG_W-1:0]  victim_tag_o,
    output logic [LINE_W-1:0] victim_data_o,
    output logic              wb_valid_o,
    output logic [IDX_W-1:0]  wb_index_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o,
    output logic              busy_o,
    output logic              flush_done_o
);

    localparam int WAY_W = $clog2(WAYS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Line storage; an age of 0 is most recently used, WAYS-1 is the LRU way.
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_cur_set;
    logic [WAY_W-1:0]  r_cur_way;

    logic              r_rsp_valid, r_hit, r_victim_valid, r_wb_valid;
    logic              r_busy, r_flush_done;
    logic [LINE_W-1:0] r_rdata, r_victim_data, r_wb_data;
    logic [TAG_W-1:0]  r_rtag, r_victim_tag, r_wb_tag;
    logic [IDX_W-1:0]  r_wb_index;

    logic              w_hit, w_inv_found, w_accept, w_last, w_cur_dirty;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_lru_way, w_tgt, w_tgt_age;
    logic              w_tgt_valid, w_tgt_dirty;

    // Tag compare, lowest invalid way and LRU way for the requested set.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[index_i][w] && (r_tag[index_i][w] == tag_i)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[index_i][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
            if (r_age[index_i][w] == WAY_W'(WAYS - 1)) begin
                w_lru_way = WAY_W'(w);
            end
        end
    end

    assign w_tgt       = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_lru_way);
    assign w_tgt_age   = r_age[index_i][w_tgt];
    assign w_tgt_valid = r_valid[index_i][w_tgt];
    assign w_tgt_dirty = r_dirty[index_i][w_tgt];
    // A flush in the same cycle wins over the request, which is then dropped.
    assign w_accept    = req_i && (r_state == S_IDLE) && !flush_i;
    assign w_last      = (r_cur_set == IDX_W'(SETS - 1)) && (r_cur_way == WAY_W'(WAYS - 1));
    assign w_cur_dirty = r_valid[r_cur_set][r_cur_way] && r_dirty[r_cur_set][r_cur_way];

    // Tag and data arrays are plain storage and keep their contents over reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && write_i) begin
            r_tag[index_i][w_tgt]  <= tag_i;
            r_data[index_i][w_tgt] <= data_i;
        end
    end

    // Control state: valid/dirty/age, flush sequencer and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
            r_state        <= S_IDLE;
            r_cur_set      <= '0;
            r_cur_way      <= '0;
            r_rsp_valid    <= 1'b0;
            r_hit          <= 1'b0;
            r_rdata        <= '0;
            r_rtag         <= '0;
            r_victim_valid <= 1'b0;
            r_victim_tag   <= '0;
            r_victim_data  <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_index     <= '0;
            r_wb_tag       <= '0;
            r_wb_data      <= '0;
            r_busy         <= 1'b0;
            r_flush_done   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_hit          <= w_hit;
                r_rdata        <= w_hit ? (write_i ? data_i : r_data[index_i][w_hit_way]) : '0;
                r_rtag         <= w_hit ? tag_i : '0;
                r_victim_valid <= write_i && !w_hit && w_tgt_valid && w_tgt_dirty;
                r_victim_tag   <= (write_i && !w_hit && w_tgt_valid && w_tgt_dirty)
                                  ? r_tag[index_i][w_tgt] : '0;
                r_victim_data  <= (write_i && !w_hit && w_tgt_valid && w_tgt_dirty)
                                  ? r_data[index_i][w_tgt] : '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_state   <= S_SCAN;
                        r_busy    <= 1'b1;
                        r_cur_set <= '0;
                        r_cur_way <= '0;
                    end else if (w_accept && (write_i || w_hit)) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == w_tgt) begin
                                r_age[index_i][w] <= '0;
                            end else if (r_age[index_i][w] < w_tgt_age) begin
                                r_age[index_i][w] <= r_age[index_i][w] + WAY_W'(1);
                            end
                        end
                        if (write_i) begin
                            r_valid[index_i][w_tgt] <= 1'b1;
                            r_dirty[index_i][w_tgt] <= w_hit ? (w_tgt_dirty | dirty_i) : dirty_i;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_cur_dirty) begin
                        r_state    <= S_WB;
                        r_wb_valid <= 1'b1;
                        r_wb_index <= r_cur_set;
                        r_wb_tag   <= r_tag[r_cur_set][r_cur_way];
                        r_wb_data  <= r_data[r_cur_set][r_cur_way];
                    end else begin
                        r_valid[r_cur_set][r_cur_way] <= 1'b0;
                        if (r_cur_way == WAY_W'(WAYS - 1)) begin
                            r_cur_way <= '0;
                            r_cur_set <= r_cur_set + IDX_W'(1);
                        end else begin
                            r_cur_way <= r_cur_way + WAY_W'(1);
                        end
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_flush_done <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready_i) begin
                        r_wb_valid                    <= 1'b0;
                        r_valid[r_cur_set][r_cur_way] <= 1'b0;
                        r_dirty[r_cur_set][r_cur_way] <= 1'b0;
                        if (r_cur_way == WAY_W'(WAYS - 1)) begin
                            r_cur_way <= '0;
                            r_cur_set <= r_cur_set + IDX_W'(1);
                        end else begin
                            r_cur_way <= r_cur_way + WAY_W'(1);
                        end
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: begin
                    r_flush_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_age[s][w] <= WAY_W'(w);
                        end
                    end
                end
            endcase
        end
    end

    assign rsp_valid_o    = r_rsp_valid;
    assign hit_o          = r_hit;
    assign data_o         = r_rdata;
    assign tag_o          = r_rtag;
    assign victim_valid_o = r_victim_valid;
    assign victim_tag_o   = r_victim_tag;
    assign victim_data_o  = r_victim_data;
    assign wb_valid_o     = r_wb_valid;
    assign wb_index_o     = r_wb_index;
    assign wb_tag_o       = r_wb_tag;
    assign wb_data_o      = r_wb_data;
    assign busy_o         = r_busy;
    assign flush_done_o   = r_flush_done;

endmodule
`default_nettype wire
